debounce_pulse: RTL and testbench

// - Stage downstream of the 3-FF button synchronizer. Consumes its already-synchronized

---
 rtl/debounce_pulse.sv | 93 +++++++++
 tb/tb_debounce_pulse.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// debounce_pulse: debounced level with press/release pulses; optional auto-repeat under DEBOUNCE_REPEAT_EN
module debounce_pulse #(
  parameter int STABLE_CYCLES = 100000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);
`ifdef DEBOUNCE_REPEAT_EN
  localparam int REP_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAX_CNT = STABLE_CYCLES > REP_MAX ? STABLE_CYCLES : REP_MAX;
`else
  localparam int MAX_CNT = STABLE_CYCLES;
`endif
  localparam int CNT_W = $clog2(MAX_CNT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("debounce_pulse: STABLE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end
  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic level_nx, rise_nx, fall_nx, rep_hit;
  // next state: count consecutive samples opposite to the current level, accept at STABLE_CYCLES
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    level_nx = btn_level;
    rise_nx = 1'b0;
    fall_nx = 1'b0;
    case (state)
      LOW: if (in_sync) begin
        state_nx = WAIT_HIGH;
        cnt_nx = CNT_W'(1);
      end
      WAIT_HIGH: if (!in_sync) state_nx = LOW;
      else if (cnt == LAST) begin
        state_nx = HIGH;
        level_nx = 1'b1;
        rise_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      HIGH: if (!in_sync) begin
        state_nx = WAIT_LOW;
        cnt_nx = CNT_W'(1);
      end
      WAIT_LOW: if (in_sync) state_nx = HIGH;
      else if (cnt == LAST) begin
        state_nx = LOW;
        level_nx = 1'b0;
        fall_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      default: state_nx = LOW;
    endcase
  end
  // state, count and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt <= '0;
      btn_level <= 1'b0;
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      btn_level <= level_nx;
      btn_rise <= rise_nx | rep_hit;
      btn_fall <= fall_nx;
    end
  end
`ifdef DEBOUNCE_REPEAT_EN
  logic [CNT_W-1:0] hold;
  logic rep_phase;
  assign rep_hit = state == HIGH && hold == (rep_phase ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1));
  // hold counter ticks only in HIGH, survives a WAIT_LOW excursion, restarts after each repeat pulse
  always_ff @(posedge clk) begin
    if (rst || !level_nx) begin
      hold <= '0;
      rep_phase <= 1'b0;
    end else if (state == HIGH) begin
      hold <= rep_hit ? '0 : hold + 1'b1;
      rep_phase <= rep_phase | rep_hit;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: directed literal checks plus randomized run against a run-length model
module tb_debounce_pulse;
  localparam int S = 4;
  localparam int D = 8;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_sync = 1'b0;
  logic btn_level, btn_rise, btn_fall;
  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;
  logic m_level = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int run = 0;
  int h = 0;
  debounce_pulse #(.STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .in_sync(in_sync),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask
  // reference model: a change is accepted after S consecutive samples differing from the level
  always @(posedge clk) begin
    bit was_high;
    if (rst) begin
      m_level = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      run = 0;
      h = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      was_high = m_level && run == 0;
      if (in_sync !== m_level) begin
        run++;
        if (run == S) begin
          m_level = ~m_level;
          run = 0;
          h = 0;
          if (m_level) m_rise = 1'b1;
          else m_fall = 1'b1;
        end
      end else run = 0;
`ifdef DEBOUNCE_REPEAT_EN
      if (was_high) begin
        h++;
        if (h == D || (h > D && (h - D) % P == 0)) m_rise = 1'b1;
      end
`endif
    end
  end
  // compare DUT against model every cycle once reset has been applied
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_level", btn_level, m_level);
      check("model_rise", btn_rise, m_rise);
      check("model_fall", btn_fall, m_fall);
      check("no_rise_and_fall", btn_rise & btn_fall, 1'b0);
    end
  end
  task automatic cyc(input logic r, input logic i);
    rst = r;
    in_sync = i;
    @(negedge clk);
  endtask
  task automatic lit(input string nm, input logic lv, input logic rs, input logic fl);
    check({nm, "_level"}, btn_level, lv);
    check({nm, "_rise"}, btn_rise, rs);
    check({nm, "_fall"}, btn_fall, fl);
    check({nm, "_mdl_level"}, m_level, lv);
    check({nm, "_mdl_rise"}, m_rise, rs);
  endtask
  initial begin
    @(negedge clk);
    cyc(1, 1);
    lit("rst1", 0, 0, 0);
    cmp_on = 1'b1;
    cyc(1, 1);
    lit("rst2", 0, 0, 0);
    cyc(0, 1);
    lit("post_rst", 0, 0, 0);
    cyc(0, 1);
    cyc(0, 1);
    lit("short3", 0, 0, 0);
    cyc(0, 0);
    lit("short_drop", 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 1);
      lit("press_wait", 0, 0, 0);
    end
    cyc(0, 1);
    lit("press", 1, 1, 0);
    cyc(0, 1);
    lit("press_after", 1, 0, 0);
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);
    lit("bounce", 1, 0, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    lit("rel_wait", 1, 0, 0);
    cyc(0, 0);
    lit("release", 0, 0, 1);
    cyc(0, 0);
    lit("release_after", 0, 0, 0);
    cyc(0, 1);
    cyc(0, 1);
    cyc(1, 1);
    lit("mid_rst", 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 1);
      lit("repress_wait", 0, 0, 0);
    end
    cyc(0, 1);
    lit("repress", 1, 1, 0);
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 1);
      lit("repeat", 1, (k inside {8, 12, 16, 20, 24, 28}) ? 1'b1 : 1'b0, 0);
    end
`endif
    for (int k = 0; k < S; k++) cyc(0, 0);
    lit("release2", 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      logic v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3 * S + 6);
      for (int k = 0; k < len; k++) cyc($urandom_range(0, 199) == 0, v);
    end
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
